// File: rtl/bcd_stopwatch_timer.sv
// N-digit BCD stopwatch/timer with tick divider and a one-button start/stop/clear controller.
// Optional lap freeze display is built when LAP_CAPTURE_EN is defined.
module bcd_stopwatch_timer #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  control_button,
    input  logic                  lap_button,
    input  logic                  count_down,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  expired,
    output logic                  overflow,
    output logic                  tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0]          state;
    logic                mode;
    logic [DIV_W-1:0]    div_cnt;
    logic [4*DIGITS-1:0] live;
    logic [2:0]          ctrl_sync;
    logic                ctrl_rise;

    logic [4*DIGITS-1:0] clamped;
    logic [4*DIGITS-1:0] up_next;
    logic [4*DIGITS-1:0] down_next;
    logic [4*DIGITS-1:0] step_next;
    logic                carry;
    logic                borrow;
    logic                live_zero;
    logic                step_en;
    logic                expire_now;

    // [0],[1] are the synchronizer flops, [2] is the edge-detect delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_sync <= '0;
        end else begin
            ctrl_sync <= {ctrl_sync[1:0], control_button};
        end
    end

    assign ctrl_rise = ctrl_sync[1] & ~ctrl_sync[2];

    always_comb begin
        clamped   = '0;
        up_next   = '0;
        down_next = '0;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            clamped[4*k +: 4] = (load_value[4*k +: 4] > 4'd9) ? 4'd9 : load_value[4*k +: 4];
            if (carry) begin
                if (live[4*k +: 4] == 4'd9) begin
                    up_next[4*k +: 4] = 4'd0;
                end else begin
                    up_next[4*k +: 4] = live[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                up_next[4*k +: 4] = live[4*k +: 4];
            end
            if (borrow) begin
                if (live[4*k +: 4] == 4'd0) begin
                    down_next[4*k +: 4] = 4'd9;
                end else begin
                    down_next[4*k +: 4] = live[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                down_next[4*k +: 4] = live[4*k +: 4];
            end
        end
    end

    assign live_zero  = (live == '0);
    assign step_en    = (state == RUN) && (div_cnt == DIV_LAST);
    // A down count sitting at zero expires without wrapping to all-9s
    assign step_next  = mode ? (live_zero ? live : down_next) : up_next;
    assign expire_now = step_en && mode && (live_zero || (down_next == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode     <= 1'b0;
            div_cnt  <= '0;
            live     <= '0;
            tick     <= 1'b0;
            expired  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    live    <= count_down ? clamped : '0;
                    if (ctrl_rise) begin
                        state <= RUN;
                        mode  <= count_down;
                    end
                end
                RUN: begin
                    if (step_en) begin
                        div_cnt <= '0;
                        tick    <= 1'b1;
                        live    <= step_next;
                        if (!mode && carry) begin
                            overflow <= 1'b1;
                        end
                        if (expire_now) begin
                            expired <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (ctrl_rise || expire_now) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (ctrl_rise) begin
                        state    <= IDLE;
                        live     <= mode ? clamped : '0;
                        expired  <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign running = (state == RUN);

`ifdef LAP_CAPTURE_EN
    logic [2:0]          lap_sync;
    logic                lap_rise;
    logic                frozen;
    logic [4*DIGITS-1:0] lap_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sync <= '0;
        end else begin
            lap_sync <= {lap_sync[1:0], lap_button};
        end
    end

    assign lap_rise = lap_sync[1] & ~lap_sync[2];

    // Clear from STOP takes priority over a coincident lap press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen  <= 1'b0;
            lap_reg <= '0;
        end else if ((state == STOP) && ctrl_rise) begin
            frozen <= 1'b0;
        end else if (lap_rise && (state != IDLE)) begin
            if (frozen) begin
                frozen <= 1'b0;
            end else begin
                frozen  <= 1'b1;
                lap_reg <= live;
            end
        end
    end

    assign digits = frozen ? lap_reg : live;
`else
    logic lap_unused;
    assign lap_unused = lap_button;
    assign digits     = live;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_timer.sv
// Directed bench for bcd_stopwatch_timer: a DIV=10 instance for most scenarios and a
// DIV=2 instance for the 9999 -> 0000 overflow wrap. Lap expectations follow LAP_CAPTURE_EN.
module tb_bcd_stopwatch_timer;

`ifdef LAP_CAPTURE_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        ctrl, lap, count_down;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic        running, expired, overflow, tick;

    logic        f_ctrl, f_lap, f_count_down;
    logic [15:0] f_load;
    logic [15:0] f_digits;
    logic        f_running, f_expired, f_overflow, f_tick;

    int errors = 0;
    int checks = 0;

    bcd_stopwatch_timer #(.DIGITS(4), .CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst_n(rst_n), .control_button(ctrl), .lap_button(lap),
        .count_down(count_down), .load_value(load_value), .digits(digits),
        .running(running), .expired(expired), .overflow(overflow), .tick(tick)
    );

    bcd_stopwatch_timer #(.DIGITS(4), .CLK_HZ(200), .TICK_HZ(100)) dut_fast (
        .clk(clk), .rst_n(rst_n), .control_button(f_ctrl), .lap_button(f_lap),
        .count_down(f_count_down), .load_value(f_load), .digits(f_digits),
        .running(f_running), .expired(f_expired), .overflow(f_overflow), .tick(f_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Button pulse; on return the action edge has just happened
    task automatic press(input bit fast, input bit on_lap);
        @(negedge clk);
        if (fast) begin if (on_lap) f_lap = 1'b1; else f_ctrl = 1'b1; end
        else      begin if (on_lap) lap = 1'b1;   else ctrl = 1'b1;   end
        repeat (3) @(negedge clk);
        if (fast) begin if (on_lap) f_lap = 1'b0; else f_ctrl = 1'b0; end
        else      begin if (on_lap) lap = 1'b0;   else ctrl = 1'b0;   end
    endtask

    task automatic wait_tick(input bit fast, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((fast ? f_tick : tick) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no tick within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (digits !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 ||
            overflow !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: digits=%h run=%b exp=%b ovf=%b tick=%b expected 0000/0/0/0/0",
                     digits, running, expired, overflow, tick);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (digits !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: digits=%h run=%b expected 0000/0", digits, running);
        end
    endtask

    task automatic test_up_count();
        bit ok;
        bit seen;
        count_down = 1'b0;
        @(negedge clk);
        ctrl = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_early: running=%b expected 0", running);
        end
        @(negedge clk);
        ctrl = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: running=%b expected 1", running);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL first_tick_early: tick=%b expected 0", tick);
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b1 || digits !== 16'h0001) begin
            errors++;
            $display("FAIL first_tick: tick=%b digits=%h expected 1/0001", tick, digits);
        end
        for (int i = 1; i < 105; i++) begin
            wait_tick(1'b0, 20, ok);
            if (!ok) break;
        end
        checks++;
        if (digits !== 16'h0105) begin
            errors++;
            $display("FAIL up_0105: digits=%h expected 0105", digits);
        end
        press(1'b0, 1'b0);
        checks++;
        if (running !== 1'b0 || digits !== 16'h0105) begin
            errors++;
            $display("FAIL stop_hold: run=%b digits=%h expected 0/0105", running, digits);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tick !== 1'b0 || digits !== 16'h0105) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL stop_static: tick or digits moved in STOP, digits=%h expected 0105", digits);
        end
        press(1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_up: digits=%h run=%b expected 0000/0", digits, running);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        count_down = 1'b0;
        @(negedge clk);
        ctrl = 1'b1;
        repeat (3) @(negedge clk);
        ctrl = 1'b0;
        repeat (7) @(negedge clk);
        ctrl = 1'b1;
        repeat (3) @(negedge clk);
        ctrl = 1'b0;
        checks++;
        if (tick !== 1'b1 || digits !== 16'h0001 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_and_stop: tick=%b digits=%h run=%b expected 1/0001/0",
                     tick, digits, running);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (digits !== 16'h0001 || running !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL tick_and_stop_hold: digits=%h run=%b expected 0001/0", digits, running);
        end
        press(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        count_down = 1'b0;
        press(1'b0, 1'b0);
        for (int i = 0; i < 42; i++) begin
            wait_tick(1'b0, 20, ok);
            if (!ok) break;
        end
        checks++;
        if (digits !== 16'h0042 || running !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_0042: digits=%h run=%b expected 0042/1", digits, running);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (digits !== 16'h0000 || running !== 1'b0 || expired !== 1'b0 ||
            overflow !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: digits=%h run=%b exp=%b ovf=%b tick=%b expected 0000/0/0/0/0",
                     digits, running, expired, overflow, tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        bit ok;
        f_count_down = 1'b0;
        press(1'b1, 1'b0);
        for (int i = 0; i < 9998; i++) begin
            wait_tick(1'b1, 8, ok);
            if (!ok) break;
        end
        checks++;
        if (f_digits !== 16'h9998 || f_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_9998: digits=%h ovf=%b expected 9998/0", f_digits, f_overflow);
        end
        wait_tick(1'b1, 8, ok);
        checks++;
        if (f_digits !== 16'h9999 || f_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_9999: digits=%h ovf=%b expected 9999/0", f_digits, f_overflow);
        end
        wait_tick(1'b1, 8, ok);
        checks++;
        if (f_digits !== 16'h0000 || f_overflow !== 1'b1 || f_running !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap: digits=%h ovf=%b run=%b expected 0000/1/1",
                     f_digits, f_overflow, f_running);
        end
        wait_tick(1'b1, 8, ok);
        checks++;
        if (f_digits !== 16'h0001 || f_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: digits=%h ovf=%b expected 0001/1", f_digits, f_overflow);
        end
        press(1'b1, 1'b0);
        checks++;
        if (f_overflow !== 1'b1 || f_running !== 1'b0) begin
            errors++;
            $display("FAIL ovf_stop: ovf=%b run=%b expected 1/0", f_overflow, f_running);
        end
        press(1'b1, 1'b0);
        checks++;
        if (f_overflow !== 1'b0 || f_digits !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b digits=%h expected 0/0000", f_overflow, f_digits);
        end
    endtask

    task automatic test_down_count();
        bit ok;
        bit seen;
        count_down = 1'b1;
        load_value = 16'h0003;
        repeat (2) @(negedge clk);
        checks++;
        if (digits !== 16'h0003) begin
            errors++;
            $display("FAIL idle_load: digits=%h expected 0003", digits);
        end
        press(1'b0, 1'b0);
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0002 || expired !== 1'b0) begin
            errors++;
            $display("FAIL down_0002: digits=%h exp=%b expected 0002/0", digits, expired);
        end
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0001 || running !== 1'b1) begin
            errors++;
            $display("FAIL down_0001: digits=%h run=%b expected 0001/1", digits, running);
        end
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0000 || expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL down_expire: digits=%h exp=%b run=%b expected 0000/1/0",
                     digits, expired, running);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tick !== 1'b0 || digits !== 16'h0000) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL expire_no_tick: tick or digits moved after expiry, digits=%h expected 0000", digits);
        end
        press(1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0003 || expired !== 1'b0) begin
            errors++;
            $display("FAIL down_clear: digits=%h exp=%b expected 0003/0", digits, expired);
        end
        load_value = 16'h0000;
        repeat (2) @(negedge clk);
        press(1'b0, 1'b0);
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0000 || expired !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL down_from_zero: digits=%h exp=%b run=%b expected 0000/1/0",
                     digits, expired, running);
        end
        press(1'b0, 1'b0);
        checks++;
        if (expired !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: exp=%b expected 0", expired);
        end
    endtask

    task automatic test_clamp_direction();
        bit ok;
        count_down = 1'b1;
        load_value = 16'hFA3B;
        repeat (2) @(negedge clk);
        checks++;
        if (digits !== 16'h9939) begin
            errors++;
            $display("FAIL clamp_all: digits=%h expected 9939", digits);
        end
        load_value = 16'h00A5;
        repeat (2) @(negedge clk);
        checks++;
        if (digits !== 16'h0095) begin
            errors++;
            $display("FAIL clamp_00a5: digits=%h expected 0095", digits);
        end
        press(1'b0, 1'b0);
        count_down = 1'b0;
        load_value = 16'h0000;
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0094) begin
            errors++;
            $display("FAIL dir_locked_1: digits=%h expected 0094", digits);
        end
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0093) begin
            errors++;
            $display("FAIL dir_locked_2: digits=%h expected 0093", digits);
        end
        press(1'b0, 1'b0);
        count_down = 1'b1;
        load_value = 16'h0100;
        press(1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0100) begin
            errors++;
            $display("FAIL clear_reload: digits=%h expected 0100", digits);
        end
        press(1'b0, 1'b0);
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0099) begin
            errors++;
            $display("FAIL borrow_0099: digits=%h expected 0099", digits);
        end
        press(1'b0, 1'b0);
        press(1'b0, 1'b0);
        count_down = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL idle_up_zero: digits=%h expected 0000", digits);
        end
    endtask

    task automatic test_lap();
        bit ok;
        count_down = 1'b0;
        press(1'b0, 1'b1);
        press(1'b0, 1'b0);
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== 16'h0001) begin
            errors++;
            $display("FAIL lap_idle_ignored: digits=%h expected 0001", digits);
        end
        for (int i = 0; i < 11; i++) begin
            wait_tick(1'b0, 20, ok);
            if (!ok) break;
        end
        checks++;
        if (digits !== 16'h0012) begin
            errors++;
            $display("FAIL lap_pre_0012: digits=%h expected 0012", digits);
        end
        press(1'b0, 1'b1);
        checks++;
        if (digits !== 16'h0012) begin
            errors++;
            $display("FAIL lap_capture: digits=%h expected 0012", digits);
        end
        for (int i = 0; i < 8; i++) begin
            wait_tick(1'b0, 20, ok);
            if (!ok) break;
        end
        checks++;
        if (digits !== (LAP_ON ? 16'h0012 : 16'h0020)) begin
            errors++;
            $display("FAIL lap_frozen: digits=%h expected %h", digits,
                     LAP_ON ? 16'h0012 : 16'h0020);
        end
        press(1'b0, 1'b1);
        checks++;
        if (digits !== 16'h0020) begin
            errors++;
            $display("FAIL lap_release: digits=%h expected 0020", digits);
        end
        press(1'b0, 1'b1);
        wait_tick(1'b0, 20, ok);
        checks++;
        if (digits !== (LAP_ON ? 16'h0020 : 16'h0021)) begin
            errors++;
            $display("FAIL lap_refreeze: digits=%h expected %h", digits,
                     LAP_ON ? 16'h0020 : 16'h0021);
        end
        press(1'b0, 1'b0);
        press(1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL lap_clear: digits=%h expected 0000", digits);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        ctrl         = 1'b0;
        lap          = 1'b0;
        count_down   = 1'b0;
        load_value   = 16'h0000;
        f_ctrl       = 1'b0;
        f_lap        = 1'b0;
        f_count_down = 1'b0;
        f_load       = 16'h0000;
        repeat (2) @(negedge clk);
        test_reset();
        test_up_count();
        test_back_to_back();
        test_reset_mid_run();
        test_overflow();
        test_down_count();
        test_clamp_direction();
        test_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
